// File: rtl/frame_loader.sv
// Byte-stream frame loader: hunts for a sync byte, packs 32 data bytes into eight
// 32-bit pixel words and writes them out over a pipelined Wishbone master port.
module frame_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_wdata,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_rdata,
  output logic        o_frame_done,
  output logic        o_err
);

  typedef enum logic [1:0] {HUNT, COLLECT, WRITE, WAIT_ACK} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] word_q, word_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic        write_done;
  logic        unused_rdata;

  // Pixel bytes are .RGB.RGB: the two pad bits never reach the word.
  function automatic logic [7:0] mask_byte(input logic [7:0] b);
    return b & 8'h77;
  endfunction

  assign accept       = i_valid && ready_q;
  assign unused_rdata = ^i_wb_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 3'd0;
      tmo_q      <= 8'd0;
      word_q     <= 32'd0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      word_q     <= word_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    word_d     = word_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    write_done = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept && (i_data == SYNC_BYTE)) begin
          state_d    = COLLECT;
          byte_cnt_d = 2'd0;
          word_cnt_d = 3'd0;
          word_d     = 32'd0;
        end
      end
      COLLECT: begin
        if (accept) begin
          word_d     = {word_q[23:0], mask_byte(i_data)};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            write_done = 1'b1;
          end else begin
            state_d = WAIT_ACK;
            tmo_d   = 8'd0;
          end
        end
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          write_done = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          // Give up on this frame; earlier words stay in the slave.
          err_d      = 1'b1;
          state_d    = HUNT;
          word_cnt_d = 3'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (write_done) begin
      if (word_cnt_q == 3'd7) begin
        done_d     = 1'b1;
        state_d    = HUNT;
        word_cnt_d = 3'd0;
      end else begin
        state_d    = COLLECT;
        word_cnt_d = word_cnt_q + 3'd1;
      end
    end

    ready_d = (state_d == HUNT) || (state_d == COLLECT);
  end

  assign o_ready      = ready_q;
  assign o_wb_cyc     = (state_q == WRITE) || (state_q == WAIT_ACK);
  assign o_wb_stb     = (state_q == WRITE);
  assign o_wb_we      = o_wb_cyc;
  assign o_wb_sel     = o_wb_cyc ? 4'hF : 4'h0;
  assign o_wb_addr    = word_cnt_q;
  assign o_wb_wdata   = word_q;
  assign o_frame_done = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: a small Wishbone responder records every accepted
// write, and one linear initial block drives the byte stream and checks results.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        ready;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdata;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;
  logic [31:0] wb_rdata = 32'h0;
  logic        frame_done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration (written only by the stimulus block)
  int       epoch = 0;
  int       stall_n = 0;
  logic [2:0] stall_addr = 3'd0;
  bit       same_cycle = 1'b0;
  bit       drop_en = 1'b0;
  logic [2:0] drop_addr = 3'd0;

  // Responder statistics (written only by the responder)
  int          seen_epoch = 0;
  int          wr_cnt, done_cnt, err_cnt, rdy_viol, unstable, stall_cnt, bad_ctl, stb_total, wait_total;
  int          stb_cyc [8];
  int          wait_cyc [8];
  logic [2:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  logic [2:0]  ref_a;
  logic [31:0] ref_d;

  localparam logic [31:0] EXP_A [8] = '{32'h11121314, 32'h15161710, 32'h11121314, 32'h15161720,
                                       32'h21222324, 32'h25262720, 32'h21222324, 32'h25262730};

  frame_loader #(.SYNC_BYTE(8'hA5), .ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_data       (in_data),
    .i_valid      (in_valid),
    .o_ready      (ready),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_sel     (wb_sel),
    .o_wb_wdata   (wb_wdata),
    .i_wb_ack     (wb_ack),
    .i_wb_stall   (wb_stall),
    .i_wb_rdata   (wb_rdata),
    .o_frame_done (frame_done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  // Slave model: looks at the DUT mid-cycle and decides stall/ack for the next edge.
  always @(negedge clk) begin
    logic a_v, s_v;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      wr_cnt = 0; done_cnt = 0; err_cnt = 0; rdy_viol = 0; unstable = 0;
      stall_cnt = 0; bad_ctl = 0; stb_total = 0; wait_total = 0;
      for (int i = 0; i < 8; i++) begin stb_cyc[i] = 0; wait_cyc[i] = 0; end
    end
    a_v = 1'b0;
    s_v = 1'b0;
    if (frame_done) done_cnt++;
    if (err) err_cnt++;
    if (wb_cyc && ready) rdy_viol++;
    if (wb_stb) begin
      stb_cyc[wb_addr]++;
      stb_total++;
      if (wb_sel !== 4'hF || wb_we !== 1'b1 || wb_cyc !== 1'b1) bad_ctl++;
      if (wb_addr == stall_addr && stall_cnt < stall_n) begin
        if (stall_cnt == 0) begin
          ref_a = wb_addr;
          ref_d = wb_wdata;
        end else if (wb_addr !== ref_a || wb_wdata !== ref_d) begin
          unstable++;
        end
        s_v = 1'b1;
        stall_cnt++;
      end else begin
        if (stall_cnt > 0 && wb_addr == stall_addr && wb_wdata !== ref_d) unstable++;
        if (wr_cnt < 16) begin
          wr_addr[wr_cnt] = wb_addr;
          wr_data[wr_cnt] = wb_wdata;
        end
        wr_cnt++;
        a_v = same_cycle;
      end
    end else if (wb_cyc) begin
      wait_cyc[wb_addr]++;
      wait_total++;
      a_v = !(drop_en && wb_addr == drop_addr);
    end
    wb_ack   = a_v;
    wb_stall = s_v;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that transfers the byte.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   waited;
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!r && waited < 200);
    if (!r) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_byte: o_ready observed 0 for %0d cycles, expected 1", waited);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit fill, input int nbytes);
    send_byte(8'hA5);
    for (int i = 0; i < nbytes; i++) send_byte(fill ? base : 8'(base + i));
    in_valid = 1'b0;
  endtask

  task automatic wait_end;
    for (int i = 0; i < 300 && done_cnt == 0 && err_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic new_epoch;
    epoch++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_cyc",   {31'd0, wb_cyc}, 32'd0);
    chk("rst_stb",   {31'd0, wb_stb}, 32'd0);
    chk("rst_we",    {31'd0, wb_we}, 32'd0);
    chk("rst_addr",  {29'd0, wb_addr}, 32'd0);
    chk("rst_sel",   {28'd0, wb_sel}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    #1 chk("ready_before_clk", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_clk", {31'd0, ready}, 32'd1);

    // Basic frame, ack one cycle after accept
    new_epoch();
    send_frame(8'h11, 1'b0, 32);
    wait_end();
    chk("A_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("A_addr%0d", i), {29'd0, wr_addr[i]}, i);
      chk($sformatf("A_word%0d", i), wr_data[i], EXP_A[i]);
    end
    chk("A_done", done_cnt, 1);
    chk("A_err", err_cnt, 0);
    chk("A_ready_in_write", rdy_viol, 0);
    chk("A_ctl", bad_ctl, 0);
    chk("A_wait_cycles", wait_total, 8);

    // Junk before sync, all-ones payload
    new_epoch();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'hFF, 1'b1, 32);
    wait_end();
    chk("B_wr_cnt", wr_cnt, 8);
    chk("B_first_addr", {29'd0, wr_addr[0]}, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("B_word%0d", i), wr_data[i], 32'h77777777);
    chk("B_done", done_cnt, 1);

    // Five stall cycles on word 3
    stall_addr = 3'd3;
    stall_n    = 5;
    new_epoch();
    send_frame(8'h11, 1'b0, 32);
    wait_end();
    chk("C_stall_cycles", stall_cnt, 5);
    chk("C_stb_cycles_w3", stb_cyc[3], 6);
    chk("C_stable", unstable, 0);
    chk("C_addr3", {29'd0, wr_addr[3]}, 3);
    chk("C_word3", wr_data[3], 32'h15161720);
    chk("C_wr_cnt", wr_cnt, 8);
    chk("C_done", done_cnt, 1);
    stall_n = 0;

    // Ack together with acceptance
    same_cycle = 1'b1;
    new_epoch();
    send_frame(8'h11, 1'b0, 32);
    wait_end();
    chk("D_stb_total", stb_total, 8);
    chk("D_wait_total", wait_total, 0);
    chk("D_word7", wr_data[7], 32'h25262730);
    chk("D_done", done_cnt, 1);
    same_cycle = 1'b0;

    // Missing ack on word 2 -> timeout, then clean restart
    drop_en   = 1'b1;
    drop_addr = 3'd2;
    new_epoch();
    send_frame(8'h11, 1'b0, 12);
    wait_end();
    chk("E_err", err_cnt, 1);
    chk("E_done", done_cnt, 0);
    chk("E_wait_w2", wait_cyc[2], 4);
    chk("E_cyc_low", {31'd0, wb_cyc}, 32'd0);
    chk("E_wr_cnt", wr_cnt, 3);
    drop_en = 1'b0;
    new_epoch();
    send_frame(8'h11, 1'b0, 32);
    wait_end();
    chk("E_restart_addr0", {29'd0, wr_addr[0]}, 0);
    chk("E_restart_word0", wr_data[0], 32'h11121314);
    chk("E_restart_wr_cnt", wr_cnt, 8);
    chk("E_restart_done", done_cnt, 1);

    // Reset while word 5 is being strobed
    stall_addr = 3'd5;
    stall_n    = 1000;
    new_epoch();
    send_frame(8'h11, 1'b0, 24);
    repeat (3) @(posedge clk);
    #1;
    chk("F_stb_before", {31'd0, wb_stb}, 32'd1);
    chk("F_addr_before", {29'd0, wb_addr}, 32'd5);
    #3 reset_n = 1'b0;
    #1;
    chk("F_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("F_stb", {31'd0, wb_stb}, 32'd0);
    chk("F_ready", {31'd0, ready}, 32'd0);
    chk("F_addr", {29'd0, wb_addr}, 32'd0);
    chk("F_sel", {28'd0, wb_sel}, 32'd0);
    chk("F_wdata", wb_wdata, 32'd0);
    stall_n = 0;
    epoch++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("F_ready_release", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 chk("F_ready_hunt", {31'd0, ready}, 32'd1);
    new_epoch();
    send_frame(8'h11, 1'b0, 32);
    wait_end();
    chk("F_wr_cnt", wr_cnt, 8);
    chk("F_word0", wr_data[0], 32'h11121314);
    chk("F_word5", wr_data[5], 32'h25262720);
    chk("F_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
